// File: rtl/dm_arb.sv
// dm_arb: shares one data memory between a core port and a debug/loader port.
// Define DM_ARB_RR_EN for round-robin arbitration; the default build gives the core fixed priority.
module dm_arb #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [15:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [15:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 32'd1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        dm_we_q, dm_we_d;
  logic        busy_q, busy_d;
  logic        c_ack_q, c_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        win_s;

  // Winner of the current IDLE sample (0 = core, 1 = debug); a lone requester always wins.
  always_comb begin
    win_s = 1'b0;
    if (c_req && d_req) begin
`ifdef DM_ARB_RR_EN
      win_s = ~last_q;
`else
      win_s = 1'b0;
`endif
    end else if (d_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and registered-output logic for the IDLE/ACCESS/ACK sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dm_we_d   = 1'b0;
    busy_d    = busy_q;
    c_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          state_d = ACCESS;
          cnt_d   = LAT_M1;
          last_d  = win_s;
          owner_d = win_s;
          we_d    = win_s ? d_we    : c_we;
          addr_d  = win_s ? d_addr  : c_addr;
          wdata_d = win_s ? d_wdata : c_wdata;
          dm_we_d = win_s ? d_we    : c_we;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          if (!we_q) begin
            if (owner_q) begin
              d_rdata_d = dm_rdata;
            end else begin
              c_rdata_d = dm_rdata;
            end
          end else begin
            c_rdata_d = c_rdata_q;
          end
          if (owner_q) begin
            d_ack_d = 1'b1;
          end else begin
            c_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight without an ack.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 16'd0;
      wdata_q   <= 32'd0;
      dm_we_q   <= 1'b0;
      busy_q    <= 1'b0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      c_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dm_we_q   <= dm_we_d;
      busy_q    <= busy_d;
      c_ack_q   <= c_ack_d;
      d_ack_q   <= d_ack_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign c_ack    = c_ack_q;
  assign d_ack    = d_ack_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign dm_we    = dm_we_q;
  assign busy     = busy_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_dm_arb.sv
// Bench for dm_arb: three instances (MEM_LAT 1, 3, 4) with a cycle-timeline model per instance.
`timescale 1ns/1ps
module tb_dm_arb;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_f;

  logic [NI-1:0] c_req, c_we, d_req, d_we;
  logic [15:0]   c_addr [NI];
  logic [15:0]   d_addr [NI];
  logic [31:0]   c_wdata [NI];
  logic [31:0]   d_wdata [NI];
  logic [31:0]   c_rdata [NI];
  logic [31:0]   d_rdata [NI];
  logic [15:0]   dm_addr [NI];
  logic [31:0]   dm_wdata [NI];
  logic [31:0]   dm_rdata [NI];
  logic [NI-1:0] c_ack, d_ack, dm_we, busy, owner;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d): got %h, expected %h at %0t", name, u, act, exp, $time);
    end
  endtask

  function automatic bit pick(input bit c, input bit d, input bit last);
    if (c && d) begin
`ifdef DM_ARB_RR_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return d;
  endfunction

  for (genvar i = 0; i < NI; i++) begin : g_inst
    localparam int L = (i == 0) ? 1 : ((i == 1) ? 3 : 4);

    dm_arb #(.MEM_LAT(L)) u_dut (
      .clk(clk), .rst_f(rst_f),
      .c_req(c_req[i]), .c_we(c_we[i]), .c_addr(c_addr[i]), .c_wdata(c_wdata[i]),
      .c_rdata(c_rdata[i]), .c_ack(c_ack[i]),
      .d_req(d_req[i]), .d_we(d_we[i]), .d_addr(d_addr[i]), .d_wdata(d_wdata[i]),
      .d_rdata(d_rdata[i]), .d_ack(d_ack[i]),
      .dm_addr(dm_addr[i]), .dm_wdata(dm_wdata[i]), .dm_we(dm_we[i]),
      .dm_rdata(dm_rdata[i]), .busy(busy[i]), .owner(owner[i])
    );

    logic [31:0] mem [16];
    assign dm_rdata[i] = mem[dm_addr[i][3:0]];
    always @(posedge clk) begin
      if (dm_we[i]) mem[dm_addr[i][3:0]] <= dm_wdata[i];
    end

    // Timeline model: a grant at edge gcyc occupies edges gcyc..gcyc+L+1.
    int          e, gcyc;
    bit          act, win, twe, m_last, m_owner;
    logic [15:0] taddr;
    logic [31:0] m_crd, m_drd, m_wd;
    bit          w;
    assign w = pick(c_req[i], d_req[i], m_last);

    always @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
        e <= 0; gcyc <= 0; act <= 1'b0; win <= 1'b0; twe <= 1'b0;
        m_last <= 1'b1; m_owner <= 1'b0; taddr <= 16'd0; m_wd <= 32'd0;
        m_crd <= 32'd0; m_drd <= 32'd0;
      end else begin
        e <= e + 1;
        if (act) begin
          if (e + 1 - gcyc == L + 1) act <= 1'b0;
          if (e + 1 - gcyc == L && !twe) begin
            if (win) m_drd <= mem[taddr[3:0]];
            else     m_crd <= mem[taddr[3:0]];
          end
        end else if (c_req[i] || d_req[i]) begin
          gcyc <= e + 1; act <= 1'b1; win <= w; m_owner <= w; m_last <= w;
          twe   <= w ? d_we[i]    : c_we[i];
          taddr <= w ? d_addr[i]  : c_addr[i];
          m_wd  <= w ? d_wdata[i] : c_wdata[i];
        end
      end
    end

    wire x_dmwe = act && (e - gcyc == 0) && twe;
    wire x_cack = act && (e - gcyc == L) && !win;
    wire x_dack = act && (e - gcyc == L) && win;

    always @(negedge clk) begin
      chk("busy",     i, 32'(busy[i]),  32'(act));
      chk("dm_we",    i, 32'(dm_we[i]), 32'(x_dmwe));
      chk("c_ack",    i, 32'(c_ack[i]), 32'(x_cack));
      chk("d_ack",    i, 32'(d_ack[i]), 32'(x_dack));
      chk("ack_excl", i, 32'(c_ack[i] & d_ack[i]), 32'd0);
      chk("owner",    i, 32'(owner[i]), 32'(m_owner));
      chk("dm_addr",  i, 32'(dm_addr[i]), 32'(taddr));
      chk("dm_wdata", i, dm_wdata[i], m_wd);
      chk("c_rdata",  i, c_rdata[i], m_crd);
      chk("d_rdata",  i, d_rdata[i], m_drd);
    end
  end

  task automatic set_req(input int u, input bit port, input bit we, input logic [15:0] a, input logic [31:0] wd);
    if (port) begin
      d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = a; d_wdata[u] = wd;
    end else begin
      c_req[u] = 1'b1; c_we[u] = we; c_addr[u] = a; c_wdata[u] = wd;
    end
  endtask

  task automatic drop(input int u, input bit port);
    if (port) d_req[u] = 1'b0;
    else      c_req[u] = 1'b0;
  endtask

  // One transaction from an idle arbiter; ack_at counts negedges after the request went up.
  task automatic run1(input int u, input bit port, input bit we, input logic [15:0] a,
                      input logic [31:0] wd, input bit drop_early,
                      output int ack_at, output int we_n, output int busy_n,
                      output int ack_n, output logic [15:0] we_addr);
    @(negedge clk);
    set_req(u, port, we, a, wd);
    ack_at = -1; we_n = 0; busy_n = 0; ack_n = 0; we_addr = 16'hFFFF;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (dm_we[u]) begin we_n++; we_addr = dm_addr[u]; end
      if (busy[u]) busy_n++;
      if (port ? d_ack[u] : c_ack[u]) begin
        ack_n++;
        if (ack_at < 0) ack_at = k;
        drop(u, port);
      end
      if (drop_early && k == 1) drop(u, port);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_f = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int ack_at, we_n, busy_n, ack_n, td, tc, cnt;
    logic [15:0] wa;
    logic [3:0] seq;

    rst_f = 1'b0;
    c_req = '0; c_we = '0; d_req = '0; d_we = '0;
    for (int u = 0; u < NI; u++) begin
      c_addr[u] = 16'd0; d_addr[u] = 16'd0; c_wdata[u] = 32'd0; d_wdata[u] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_owner", 0, 32'(owner[0]), 32'd0);
    chk("rst_busy",  2, 32'(busy[2]),  32'd0);
    chk("rst_crd",   1, c_rdata[1], 32'd0);
    rst_f = 1'b1;

    // MEM_LAT=1 core write
    run1(0, 1'b0, 1'b1, 16'h0008, 32'h12345678, 1'b0, ack_at, we_n, busy_n, ack_n, wa);
    chk("w_ack_at", 0, 32'(ack_at), 32'd2);
    chk("w_we_n",   0, 32'(we_n),   32'd1);
    chk("w_we_adr", 0, 32'(wa),     32'h0008);
    chk("w_busy_n", 0, 32'(busy_n), 32'd2);
    chk("w_ack_n",  0, 32'(ack_n),  32'd1);

    // MEM_LAT=3: core write/read, then debug write/read
    run1(1, 1'b0, 1'b1, 16'h0005, 32'hA5A50001, 1'b0, ack_at, we_n, busy_n, ack_n, wa);
    run1(1, 1'b0, 1'b0, 16'h0005, 32'h0, 1'b0, ack_at, we_n, busy_n, ack_n, wa);
    chk("c_rd_val", 1, c_rdata[1], 32'hA5A50001);
    chk("c_rd_at",  1, 32'(ack_at), 32'd4);
    run1(1, 1'b1, 1'b1, 16'h0003, 32'hDEADBEEF, 1'b0, ack_at, we_n, busy_n, ack_n, wa);
    run1(1, 1'b1, 1'b0, 16'h0003, 32'h0, 1'b0, ack_at, we_n, busy_n, ack_n, wa);
    chk("d_rd_val", 1, d_rdata[1], 32'hDEADBEEF);
    chk("d_rd_at",  1, 32'(ack_at), 32'd4);
    chk("c_rd_keep", 1, c_rdata[1], 32'hA5A50001);

    // Core request arriving during a debug transaction
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 16'h0006, 32'h00000666);
    td = -1; tc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) set_req(1, 1'b0, 1'b0, 16'h0006, 32'h0);
      if (d_ack[1] && td < 0) begin td = k; drop(1, 1'b1); end
      if (c_ack[1] && tc < 0) begin tc = k; drop(1, 1'b0); end
    end
    chk("seq_dack", 1, 32'(td), 32'd4);
    chk("seq_gap",  1, 32'(tc - td), 32'd5);
    chk("seq_crd",  1, c_rdata[1], 32'h00000666);

    // Request dropped in the first ACCESS cycle still completes
    run1(2, 1'b0, 1'b1, 16'h0002, 32'h42420042, 1'b1, ack_at, we_n, busy_n, ack_n, wa);
    chk("early_ack_n", 2, 32'(ack_n),  32'd1);
    chk("early_at",    2, 32'(ack_at), 32'd5);

    // Reset during ACCESS of a MEM_LAT=4 write
    @(negedge clk);
    set_req(2, 1'b0, 1'b1, 16'h0009, 32'h00000099);
    @(posedge clk);
    #1;
    chk("pre_rst_we", 2, 32'(dm_we[2]), 32'd1);
    rst_f = 1'b0;
    #1;
    chk("rst_we",   2, 32'(dm_we[2]), 32'd0);
    chk("rst_busy", 2, 32'(busy[2]),  32'd0);
    chk("rst_acks", 2, 32'({c_ack[2], d_ack[2]}), 32'd0);
    drop(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_f = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (c_ack[2] || d_ack[2]) cnt++;
    end
    chk("no_ack_after_rst", 2, 32'(cnt), 32'd0);
    run1(2, 1'b0, 1'b0, 16'h0002, 32'h0, 1'b0, ack_at, we_n, busy_n, ack_n, wa);
    chk("post_rst_at",  2, 32'(ack_at), 32'd5);
    chk("post_rst_val", 2, c_rdata[2], 32'h42420042);

    // Both ports requesting continuously for four transactions
    do_reset();
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0008, 32'h0);
    set_req(0, 1'b1, 1'b0, 16'h0008, 32'h0);
    seq = 4'd0; cnt = 0;
    for (int k = 0; k < 40 && cnt < 4; k++) begin
      @(negedge clk);
      if (c_ack[0] || d_ack[0]) begin
        seq[cnt] = owner[0];
        cnt++;
        if (cnt == 4) begin drop(0, 1'b0); drop(0, 1'b1); end
      end
    end
    drop(0, 1'b0); drop(0, 1'b1);
    chk("tie_cnt", 0, 32'(cnt), 32'd4);
`ifdef DM_ARB_RR_EN
    chk("tie_owners", 0, 32'(seq), 32'b1010);
`else
    chk("tie_owners", 0, 32'(seq), 32'b0000);
`endif
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
